// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised single-clock FIFO; define FIFO_FWFT_EN for first-word-fall-through
module param_fifo #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read_en,
  input  logic                       write_en,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              rd_acc;
  logic              wr_acc;

  // Accept decisions, pointer/count updates, and next-state flags from the next count
  always_comb begin
    rd_acc   = read_en & ~empty_q;
    wr_acc   = write_en & (~full_q | rd_acc);

    wr_ptr_d = wr_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CNT_W'(AF_THRESH));
    ae_d    = (count_d <= CNT_W'(AE_THRESH));
    ovf_d   = write_en & ~wr_acc;
    unf_d   = read_en & ~rd_acc;

`ifdef FIFO_FWFT_EN
    // Present the head of the next state; a word written into an
    // otherwise-empty FIFO is forwarded straight from data_in.
    if (count_d == '0) begin
      dout_d = dout_q;
    end else if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
      dout_d = data_in;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
`else
    dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
`endif
  end

  // Storage array: written only on accepted pushes, never cleared
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out     = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - randomized and directed bench for param_fifo against a queue model
module tb_param_fifo;

  localparam int DW = 4;
  localparam int DP = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          read_en = 1'b0;
  logic          write_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  int total = 0;
  int bad = 0;

  param_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // reference model: contents as a queue, plus the visible output word and error pulses
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_dout = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  bit            m_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // advance the model on every rising edge using the inputs held since the last falling edge
  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_dout  = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit r_ok, w_ok;
      r_ok = read_en && (m_q.size() > 0);
      w_ok = write_en && ((m_q.size() < DP) || r_ok);
      m_ovf = write_en && !w_ok;
      m_unf = read_en && !r_ok;
      if (r_ok) begin
`ifdef FIFO_FWFT_EN
        void'(m_q.pop_front());
`else
        m_dout = m_q.pop_front();
`endif
      end
      if (w_ok) m_q.push_back(data_in);
`ifdef FIFO_FWFT_EN
      if (m_q.size() > 0) m_dout = m_q[0];
`endif
    end
  end

  // compare every DUT output against the model away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("count", 32'(count), 32'(m_q.size()));
      check("full", 32'(full), 32'(m_q.size() == DP));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("almost_full", 32'(almost_full), 32'(m_q.size() >= AF));
      check("almost_empty", 32'(almost_empty), 32'(m_q.size() <= AE));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      check("data_out", 32'(data_out), 32'(m_dout));
    end
  end

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
    @(negedge clk);
    write_en = w;
    read_en  = r;
    data_in  = d;
    reset    = rs;
    @(posedge clk);
    #1;
  endtask

  // pop one word and pin the expected value by hand for either read mode
  task automatic pop_expect(input logic [DW-1:0] e, input string nm);
`ifdef FIFO_FWFT_EN
    check(nm, 32'(data_out), 32'(e));
    step(1'b0, 1'b1, '0, 1'b0);
`else
    step(1'b0, 1'b1, '0, 1'b0);
    check(nm, 32'(data_out), 32'(e));
`endif
  endtask

  initial begin
    logic [DW-1:0] exp5 [8];
    int pw, pr;

    // reset state
    step(1'b0, 1'b0, '0, 1'b1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout", 32'(data_out), 32'd0);

    // three writes then a single read
    step(1'b1, 1'b0, 4'd5, 1'b0);
    step(1'b1, 1'b0, 4'd7, 1'b0);
    step(1'b1, 1'b0, 4'd11, 1'b0);
`ifdef FIFO_FWFT_EN
    check("t1_fwft_head", 32'(data_out), 32'd5);
`endif
    step(1'b0, 1'b1, '0, 1'b0);
    check("t1_count", 32'(count), 32'd2);
    check("t1_ae", 32'(almost_empty), 32'd1);
`ifdef FIFO_FWFT_EN
    check("t1_dout", 32'(data_out), 32'd7);
`else
    check("t1_dout", 32'(data_out), 32'd5);
`endif

    // fill to full, overflow, drain in order
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 4'(i), 1'b0);
      check("t2_af", 32'(almost_full), 32'(i >= 6));
    end
    check("t2_full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 4'd15, 1'b0);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_cnt", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) pop_expect(4'(i), "t2_order");

    // underflow on empty
    step(1'b0, 1'b1, '0, 1'b0);
    check("t3_unf", 32'(underflow), 32'd1);
    check("t3_dout", 32'(data_out), 32'd8);
    check("t3_cnt", 32'(count), 32'd0);

    // simultaneous read/write on a full FIFO
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 4'(i), 1'b0);
`ifdef FIFO_FWFT_EN
    check("t4_head", 32'(data_out), 32'd1);
`endif
    step(1'b1, 1'b1, 4'd9, 1'b0);
    check("t4_cnt", 32'(count), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd0);
`ifndef FIFO_FWFT_EN
    check("t4_dout", 32'(data_out), 32'd1);
`endif
    for (int i = 2; i <= 9; i++) pop_expect(4'(i), "t4_order");

    // pointer wrap
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 4'(i), 1'b0);
    for (int i = 1; i <= 4; i++) pop_expect(4'(i), "t5_first");
    for (int i = 10; i <= 13; i++) step(1'b1, 1'b0, 4'(i), 1'b0);
    exp5 = '{4'd5, 4'd6, 4'd7, 4'd8, 4'hA, 4'hB, 4'hC, 4'hD};
    for (int i = 0; i < 8; i++) pop_expect(exp5[i], "t5_wrap");

    // mid-operation reset
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 4'(i + 2), 1'b0);
    check("t6_cnt5", 32'(count), 32'd5);
    step(1'b1, 1'b1, 4'd3, 1'b1);
    check("t6_cnt", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_dout", 32'(data_out), 32'd0);

    // randomized traffic in write-heavy, balanced and read-heavy phases
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 50; pr = 50; end
        default: begin pw = 25; pr = 80; end
      endcase
      step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
           4'($urandom), 1'($urandom_range(0, 299) == 0));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
